// File: rtl/core_sequencer.sv
// core_sequencer: issues Core instruction addresses from a start/length descriptor
// and collects each Core result, tagged with its run index, after the fixed latency.
module core_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 18,
    parameter int unsigned LATENCY       = 3
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     Start,
    input  logic [ADDRESS_WIDTH-1:0] Base_Addr,
    input  logic [ADDRESS_WIDTH-1:0] Length,
    input  logic                     Mode,
    input  logic                     Stall,
    input  logic [DATA_WIDTH-1:0]    Core_Result,
    output logic [ADDRESS_WIDTH-1:0] Counter,
    output logic                     Result_Valid,
    output logic [DATA_WIDTH-1:0]    Result_Data,
    output logic [ADDRESS_WIDTH-1:0] Result_Index,
    output logic                     Busy,
    output logic                     Done
);
    typedef enum logic [1:0] {st_idle, st_issue, st_drain, st_done} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] addr_one = ADDRESS_WIDTH'(1);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] remaining;
    logic [ADDRESS_WIDTH-1:0] issue_idx;
    logic [1:0]               pace;
    logic                     seq_mode;
    logic [LATENCY-1:0]       line_vld;
    logic [ADDRESS_WIDTH-1:0] line_idx [LATENCY];

    logic                     pace_end;
    logic                     pending;
    logic                     load;
    logic                     issue;
    logic                     ins_vld;
    logic [ADDRESS_WIDTH-1:0] ins_idx;

    // Last unstalled cycle of the current pace period (every cycle in pipelined mode).
    assign pace_end = !Stall && (seq_mode ? (pace == 2'd2) : 1'b1);

    // Entries still in flight after this edge's shift; the output stage leaves now.
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < LATENCY; i++)
            pending = pending | line_vld[i];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= st_idle;
        else        state <= state_nxt;
    end

    // Completion is keyed to the tracking line emptying, so Done timing is
    // independent of the pace period when LATENCY is shorter than it.
    always_comb begin
        state_nxt = state;
        case (state)
            st_idle:  if (Start) state_nxt = (Length != '0) ? st_issue : st_done;
            st_issue: if (remaining == '0) begin
                          if (!pending)     state_nxt = st_done;
                          else if (pace_end) state_nxt = st_drain;
                      end
            st_drain: if (!pending) state_nxt = st_done;
            st_done:  state_nxt = st_idle;
            default:  state_nxt = st_idle;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        issue = 1'b0;
        case (state)
            st_idle:  load  = Start && (Length != '0);
            st_issue: issue = pace_end && (remaining != '0);
            default:  ;
        endcase
        ins_vld = load | issue;
        ins_idx = load ? '0 : issue_idx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Counter   <= '0;
            remaining <= '0;
            issue_idx <= '0;
            pace      <= '0;
            seq_mode  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= (state == st_done);
            if (load) begin
                Counter   <= Base_Addr;
                remaining <= Length - addr_one;
                issue_idx <= addr_one;
                pace      <= '0;
                seq_mode  <= !Mode;
                Busy      <= 1'b1;
            end else begin
                if (state == st_issue && !Stall)
                    pace <= pace_end ? 2'd0 : pace + 2'd1;
                if (issue) begin
                    Counter   <= Counter + addr_one;
                    remaining <= remaining - addr_one;
                    issue_idx <= issue_idx + addr_one;
                end
                if (state == st_done)
                    Busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            line_vld     <= '0;
            for (int unsigned i = 0; i < LATENCY; i++)
                line_idx[i] <= '0;
            Result_Valid <= 1'b0;
            Result_Data  <= '0;
            Result_Index <= '0;
        end else begin
            line_vld[0] <= ins_vld;
            line_idx[0] <= ins_idx;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                line_vld[i] <= line_vld[i-1];
                line_idx[i] <= line_idx[i-1];
            end
            Result_Valid <= line_vld[LATENCY-1];
            if (line_vld[LATENCY-1]) begin
                Result_Data  <= Core_Result;
                Result_Index <= line_idx[LATENCY-1];
            end
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: Core modelled as f(addr)=3*addr+1 with 3-cycle
// latency; expected results are queued at stimulus time and popped on Result_Valid.
module tb_core_sequencer;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 18;
    localparam int unsigned LAT = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          Start;
    logic [AW-1:0] Base_Addr;
    logic [AW-1:0] Length;
    logic          Mode;
    logic          Stall;
    logic [DW-1:0] Core_Result;
    logic [AW-1:0] Counter;
    logic          Result_Valid;
    logic [DW-1:0] Result_Data;
    logic [AW-1:0] Result_Index;
    logic          Busy;
    logic          Done;

    core_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .Base_Addr(Base_Addr),
        .Length(Length), .Mode(Mode), .Stall(Stall), .Core_Result(Core_Result),
        .Counter(Counter), .Result_Valid(Result_Valid), .Result_Data(Result_Data),
        .Result_Index(Result_Index), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return DW'(a) * DW'(3) + DW'(1);
    endfunction

    // Two registers: a Counter change at edge e is visible to capture at edge e+3.
    logic [DW-1:0] core_p1, core_p2;
    always @(posedge CLK) begin
        core_p1 <= f(Counter);
        core_p2 <= core_p1;
    end
    assign Core_Result = core_p2;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        int unsigned   cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_res(input logic [AW-1:0] addr, input logic [AW-1:0] idx,
                              input int unsigned at);
        exp_t e;
        e.data = f(addr);
        e.idx  = idx;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && Result_Valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL spurious_valid: observed index=%0d at edge %0d, expected no result",
                       Result_Index, cyc);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("res_data", 32'(Result_Data), 32'(mon_e.data));
                chk("res_index", 32'(Result_Index), 32'(mon_e.idx));
                chk("res_edge", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_start(input logic [AW-1:0] base, input logic [AW-1:0] len,
                               input logic mode);
        Start     = 1'b1;
        Base_Addr = base;
        Length    = len;
        Mode      = mode;
    endtask

    // After the accepting edge, descriptor inputs change to prove they were latched.
    task automatic scramble();
        Start     = 1'b0;
        Base_Addr = AW'($urandom);
        Length    = AW'($urandom);
        Mode      = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int unsigned exp_edge);
        int unsigned n = 0;
        while (Done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done_edge"}, cyc, exp_edge);
        chk({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned   s;
        logic [AW-1:0] a;

        RST_N = 1'b0; Start = 1'b0; Base_Addr = '0; Length = '0; Mode = 1'b0; Stall = 1'b0;
        tick();
        chk("rst_counter", 32'(Counter), 32'd0);
        chk("rst_valid", 32'(Result_Valid), 32'd0);
        chk("rst_data", 32'(Result_Data), 32'd0);
        chk("rst_index", 32'(Result_Index), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // Pipelined, base 0, length 4
        drive_start(AW'(0), AW'(4), 1'b1);
        s = cyc + 1;
        for (int unsigned k = 0; k < 4; k++) expect_res(AW'(k), AW'(k), s + k + LAT);
        tick();
        scramble();
        chk("t1_busy", 32'(Busy), 32'd1);
        for (int unsigned k = 0; k < 4; k++) begin
            if (k != 0) tick();
            chk("t1_counter", 32'(Counter), k);
        end
        wait_done("t1", s + 7);

        // Sequential, base 10, length 3, started at the earliest edge after Done
        drive_start(AW'(10), AW'(3), 1'b0);
        s = cyc + 1;
        for (int unsigned k = 0; k < 3; k++) expect_res(AW'(10 + k), AW'(k), s + 3 * k + LAT);
        tick();
        scramble();
        chk("t2_busy", 32'(Busy), 32'd1);
        chk("t2_done_low", 32'(Done), 32'd0);
        for (int unsigned i = 0; i < 9; i++) begin
            if (i != 0) tick();
            chk("t2_counter", 32'(Counter), 10 + i / 3);
        end
        wait_done("t2", s + 10);

        // Address wrap, base 1022, length 4
        drive_start(AW'(1022), AW'(4), 1'b1);
        s = cyc + 1;
        for (int unsigned k = 0; k < 4; k++) expect_res(AW'(1022 + k), AW'(k), s + k + LAT);
        tick();
        scramble();
        for (int unsigned k = 0; k < 4; k++) begin
            if (k != 0) tick();
            a = AW'(1022 + k);
            chk("t3_counter", 32'(Counter), 32'(a));
        end
        wait_done("t3", s + 7);

        // Two stall cycles after the 2nd issue, plus an ignored mid-run Start
        drive_start(AW'(100), AW'(4), 1'b1);
        s = cyc + 1;
        expect_res(AW'(100), AW'(0), s + 3);
        expect_res(AW'(101), AW'(1), s + 4);
        expect_res(AW'(102), AW'(2), s + 7);
        expect_res(AW'(103), AW'(3), s + 8);
        tick();
        scramble();
        chk("t4_counter_s0", 32'(Counter), 32'd100);
        tick();
        chk("t4_counter_s1", 32'(Counter), 32'd101);
        Stall = 1'b1;
        drive_start(AW'(500), AW'(7), 1'b0);
        tick();
        chk("t4_counter_stall1", 32'(Counter), 32'd101);
        tick();
        chk("t4_counter_stall2", 32'(Counter), 32'd101);
        Stall = 1'b0;
        scramble();
        tick();
        chk("t4_counter_s4", 32'(Counter), 32'd102);
        tick();
        chk("t4_counter_s5", 32'(Counter), 32'd103);
        chk("t4_busy", 32'(Busy), 32'd1);
        wait_done("t4", s + 9);

        // Zero-length run
        drive_start(AW'(7), AW'(0), 1'b1);
        s = cyc + 1;
        tick();
        scramble();
        chk("t5_busy", 32'(Busy), 32'd0);
        chk("t5_counter", 32'(Counter), 32'd103);
        wait_done("t5", s + 1);
        chk("t5_counter_after", 32'(Counter), 32'd103);

        // Asynchronous reset in the middle of a length-8 run
        tick();
        drive_start(AW'(200), AW'(8), 1'b1);
        s = cyc + 1;
        expect_res(AW'(200), AW'(0), s + 3);
        expect_res(AW'(201), AW'(1), s + 4);
        tick();
        scramble();
        for (int unsigned i = 0; i < 4; i++) tick();
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("t6_counter", 32'(Counter), 32'd0);
        chk("t6_valid", 32'(Result_Valid), 32'd0);
        chk("t6_data", 32'(Result_Data), 32'd0);
        chk("t6_index", 32'(Result_Index), 32'd0);
        chk("t6_busy", 32'(Busy), 32'd0);
        chk("t6_done", 32'(Done), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        for (int unsigned i = 0; i < 6; i++) tick();
        chk("t6_sb_empty", sb.size(), 32'd0);
        chk("t6_busy_after", 32'(Busy), 32'd0);

        // Normal run after reset
        drive_start(AW'(5), AW'(2), 1'b1);
        s = cyc + 1;
        for (int unsigned k = 0; k < 2; k++) expect_res(AW'(5 + k), AW'(k), s + k + LAT);
        tick();
        scramble();
        chk("t7_counter0", 32'(Counter), 32'd5);
        tick();
        chk("t7_counter1", 32'(Counter), 32'd6);
        wait_done("t7", s + 5);

        for (int unsigned i = 0; i < 4; i++) tick();
        chk("final_sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Program sequencer for the pipelined calculator `Core`. It drives the `Counter` instruction-address input of `Core` from a start/length descriptor. Issue pacing is either one address per cycle (pipelined mode) or one address every 3 cycles (sequential mode). It tracks every issued address through `Core`'s fixed latency, captures each `Result` exactly once with its sequence index, and reports run completion. The block sits between the system controller and `Core`, replacing any free-running address counter.

## Interface
- `ADDRESS_WIDTH`, 10, width of `Counter`, `Base_Addr`, `Length`, `Result_Index`
- `DATA_WIDTH`, 18, width of `Core` result data
- `LATENCY`, 3, cycles from a `Counter` update to the matching valid `Core_Result`; legal values 1..8
- `CLK`  in  1  clock, all state updates on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `Start`  in  1  begin a run; sampled only in IDLE
- `Base_Addr`  in  ADDRESS_WIDTH  first instruction address; latched at Start
- `Length`  in  ADDRESS_WIDTH  number of instructions to issue; latched at Start
- `Mode`  in  1  1 = pipelined (issue period P=1), 0 = sequential (P=3); latched at Start
- `Stall`  in  1  1 = hold issue this cycle; in-flight results keep draining
- `Core_Result`  in  DATA_WIDTH  `Result` output of `Core`
- `Counter`  out  ADDRESS_WIDTH  address to `Core`
- `Result_Valid`  out  1  one-cycle strobe; `Result_Data` and `Result_Index` are valid
- `Result_Data`  out  DATA_WIDTH  captured `Core_Result`
- `Result_Index`  out  ADDRESS_WIDTH  ordinal of the result within the run, 0..Length-1
- `Busy`  out  1  run in progress
- `Done`  out  1  one-cycle strobe at run completion

## Operation
- FSM states:
  - IDLE: waits for `Start`.
  - ISSUE: issuing addresses.
  - DRAIN: waiting for in-flight results.
  - DONE: single cycle, strobes `Done`.
- IDLE transitions:
  - `Start`=1 with `Length`≠0 → ISSUE. `Counter`←`Base_Addr` (first issue), `Busy`←1, remaining←`Length`-1, pace←0.
  - `Start`=1 with `Length`=0 → DONE. No issue; `Counter` unchanged.
- ISSUE:
  - Pace counter counts 0..P-1 and advances only when `Stall`=0.
  - An issue slot occurs when pace wraps to 0, `Stall`=0 and remaining>0. In that slot: `Counter`←`Counter`+1 modulo 2^ADDRESS_WIDTH, remaining decrements.
  - When the last address has been issued and its pace period has elapsed, go to DRAIN.
  - In sequential mode each address is held on `Counter` for exactly 3 unstalled cycles.
- Tracking: a LATENCY-deep shift line carries {issue bit, index}, shifting every cycle regardless of `Stall`. When its output bit is 1:
  - `Result_Data`←`Core_Result`
  - `Result_Index`←index
  - `Result_Valid`←1 for one cycle
- DRAIN → DONE when the shift line holds no set bit. DONE raises `Done` and drops `Busy` on the same edge, then returns to IDLE.
- `Start` while `Busy`=1 is ignored. Changes to `Base_Addr`, `Length` or `Mode` during a run are ignored.
- `Counter` holds the last issued address after a run. `Result_Data` and `Result_Index` hold their last values.
- Reset (`RST_N`=0, any time, including mid-run):
  - Immediately: FSM→IDLE, shift line cleared, `Counter`, `Result_Data`, `Result_Index` = 0, `Result_Valid`, `Busy`, `Done` = 0.
  - No stale `Result_Valid` after release.

## Timing
- `Start` is sampled at edge s. `Counter`=`Base_Addr` and `Busy`=1 from edge s.
- Unstalled issue k (k=0..N-1) occurs at edge s+k·P.
- The matching `Result_Valid` is high for one cycle following edge s+k·P+LATENCY.
- `Done` is high for one cycle following edge s+(N-1)·P+LATENCY+1. `Busy` falls at that same edge.
- Each stalled cycle in ISSUE delays all later issues, valids and `Done` by exactly 1 cycle.
- `Length`=0: `Done` strobes after edge s+1. `Busy` stays 0.
- The earliest next `Start` is accepted at the edge after `Done`.

## Test plan
The bench models `Core` as a LATENCY-cycle delay of f(addr)=3·addr+1. All scenarios use LATENCY=3.
- Pipelined run, `Base_Addr`=0, `Length`=4, `Mode`=1 → `Counter` 0,1,2,3 on edges s..s+3. `Result_Valid` at s+3..s+6 with data 1,4,7,10 and index 0..3. `Done` at s+7.
- Sequential run, `Base_Addr`=10, `Length`=3, `Mode`=0 → `Counter` holds 10,11,12 for 3 cycles each. Valids at s+3, s+6, s+9 with data 31,34,37. `Done` at s+10.
- Address wrap, `Base_Addr`=1022, `Length`=4, `Mode`=1 → `Counter` 1022,1023,0,1. Data 3067,3070,1,4. Index 0,1,2,3.
- `Stall`=1 for 2 cycles after the 2nd issue of a pipelined `Length`=4 run → `Counter` frozen 2 cycles. 2-cycle gap between the 2nd and 3rd valid. `Done` at s+9. `Start` pulsed mid-run has no effect.
- `Length`=0 → `Done` at s+1, `Busy` never high, `Counter` unchanged, no `Result_Valid`.
- `RST_N` pulsed low during a `Length`=8 run → all outputs 0 asynchronously, no `Result_Valid` after release. A following `Length`=2 run completes normally with index 0,1.
